alien_bomb: RTL and testbench
=============================

Name: alien_bomb

Overview:
- Downward counterpart of the player shot: manages up to N_BOMBS alien bombs falling toward the player.
- Picks a pseudo-random alien column and requests a launch origin from the alien controller via req/ack.
- Moves bombs once per frame, detects bomb-vs-player overlap, and drives the bomb pixel for the renderer.

Parameters:
- N_BOMBS, 3, number of simultaneous bomb slots (1..4)
- N_COLS, 11, alien columns (8..16)
- BOMB_WIDTH, 2, bomb width in pixels
- BOMB_HEIGHT, 6, bomb height in pixels
- BOMB_VELOCITY, 2, pixels per frame downward
- Y_BOTTOM_LIMIT, 460, bomb retires when its top exceeds this value
- COOLDOWN_FRAMES, 45, minimum frames between launches
- LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
- s_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_0  in  1  one-cycle frame tick (60 Hz)
- pause  in  1  freeze all state while high
- fire_req  out  1  launch request to alien controller
- fire_col  out  4  requested column, valid while fire_req is high
- fire_ack  in  1  one-cycle controller response
- fire_valid  in  1  qualifies fire_ack: column holds a live alien
- fire_x  in  10  origin X (column centre), sampled on fire_ack
- fire_y  in  10  origin Y (alien bottom), sampled on fire_ack
- player_x  in  10  player box left
- player_y  in  10  player box top
- player_w  in  6  player box width
- player_h  in  6  player box height
- pixel_x  in  10  render X
- pixel_y  in  10  render Y
- bomb_pixel  out  1  combinational: pixel lies inside any active bomb
- player_hit  out  1  one-cycle pulse when any bomb hits the player
- bombs_active  out  N_BOMBS  per-slot active flags

Behaviour:
- Reset: all slots inactive with x=y=0; FSM=IDLE; cooldown=COOLDOWN_FRAMES; LFSR=LFSR_SEED; fire_req=0, player_hit=0, bombs_active=0.
- pause high: no register changes except reset. Outputs hold their values; bomb_pixel still renders. fire_req stays asserted if the FSM is in REQ, and acks arriving during pause are ignored.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. Steps once per clk_0 tick when not paused.
- Column: c=lfsr[3:0]; fire_col = (c>=N_COLS) ? c-N_COLS : c.
- FSM IDLE:
  - On each tick, decrement cooldown while it is nonzero.
  - When cooldown==0 and a free slot exists, go to REQ on the next tick.
  - If all slots are full, stay in IDLE with cooldown held at 0.
- FSM REQ:
  - fire_req=1 and fire_col is frozen for the whole request.
  - fire_ack && fire_valid: load the lowest-index free slot with x=fire_x-BOMB_WIDTH/2 and y=fire_y, set it active. Go to IDLE and reload cooldown.
  - fire_ack && !fire_valid: go to IDLE with cooldown=1, so the request retries with a new column next frame.
  - fire_req drops in the cycle after the ack.
- Motion, on a clk_0 tick with pause low, per active slot: y_new=y+BOMB_VELOCITY (10-bit).
  - If box(x, y_new) overlaps the player box (inclusive bounds, 11-bit compare): clear the slot and flag a hit.
  - Else if y_new > Y_BOTTOM_LIMIT: clear the slot.
  - Else y=y_new.
- Hit has priority over the bottom-limit check.
- Multiple hits in one tick produce a single player_hit pulse, registered 1 cycle after the tick; all hitting slots clear.
- A slot loaded by an ack in the same cycle as a tick is not moved in that tick.
- Reset during REQ: fire_req deasserts the next cycle.

Optional Feature:
- Macro: BOMB_SHOT_CANCEL_EN.
- Defined:
  - Adds inputs shot_x[9:0], shot_y[9:0], shot_active (a 2x8 player-shot box) and output shot_cancel.
  - On a tick, a bomb whose post-move box overlaps an active shot clears, and shot_cancel pulses one cycle alongside player_hit timing.
  - Player hit takes priority over shot cancellation for the same slot.
- Undefined: none of these ports exist, and bombs pass through player shots.

Decomposition:
- Shared package game_pkg: screen limits (Y_BOTTOM_LIMIT, X bounds 32/608), the 10-bit coordinate type, and the FSM state encoding (IDLE, REQ).
- Sub-module bomb_lfsr: 8-bit LFSR with step enable and seed parameter.
- Slot array and FSM stay in alien_bomb.

Test Plan:
- Reset, no pause, controller acks valid with x=100, y=200 -> fire_req rises at frame 45. Slot0 loads x=99, y=200, then y=202, 204, ... per tick.
- Bomb at y=458 with limit 460 -> next tick y_new=460 is kept; the following tick y_new=462 clears the slot with no player_hit.
- Player box at (90,220,16,8), bomb at x=99, y=212 -> tick gives y_new=214, overlap, player_hit=1 for exactly 1 cycle, slot cleared.
- All 3 slots active -> fire_req stays 0 and cooldown is held at 0. When one slot frees on tick T, fire_req asserts on tick T+1.
- fire_ack with fire_valid=0 -> no slot loads, fire_req drops, then re-asserts next frame with the next LFSR column.
- pause=1 for 10 frames mid-REQ and mid-flight -> positions, cooldown, LFSR and fire_req are unchanged. Resume continues from the exact prior state.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: screen geometry, coordinate type, launch FSM encoding and small
// helpers shared by the alien bomb logic.
package game_pkg;
  localparam int COORD_W        = 10;
  localparam int Y_BOTTOM_LIMIT = 460;
  localparam int X_MIN          = 32;
  localparam int X_MAX          = 608;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {IDLE, REQ} fire_state_t;

  // Fold the low LFSR nibble into the column range [0, n_cols).
  function automatic logic [3:0] col_fold(input logic [7:0] l, input int n_cols);
    logic [4:0] c;
    c = {1'b0, l[3:0]};
    if (c >= 5'(n_cols)) c = c - 5'(n_cols);
    return c[3:0];
  endfunction

  // Inclusive-bound rectangle overlap on 11-bit (carry-safe) coordinates.
  function automatic logic box_overlap(input logic [10:0] ax0, ax1, ay0, ay1,
                                       input logic [10:0] bx0, bx1, by0, by1);
    return (ax0 <= bx1) && (bx0 <= ax1) && (ay0 <= by1) && (by0 <= ay1);
  endfunction
endpackage

// File: rtl/alien_bomb_if.sv
// alien_bomb_if: launch handshake between the bomb block (master) and the
// alien controller (slave).
//   fire_req/fire_col   : request and column, master -> slave
//   fire_ack/fire_valid : one-cycle response, valid = column has a live alien
//   fire_x/fire_y       : launch origin, sampled with fire_ack
interface alien_bomb_if;
  import game_pkg::*;
  logic       fire_req;
  logic [3:0] fire_col;
  logic       fire_ack;
  logic       fire_valid;
  coord_t     fire_x;
  coord_t     fire_y;

  modport master (output fire_req, fire_col, input fire_ack, fire_valid, fire_x, fire_y);
  modport slave  (input fire_req, fire_col, output fire_ack, fire_valid, fire_x, fire_y);
endinterface

// File: rtl/bomb_lfsr.sv
// bomb_lfsr: 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, right-shifting.
//   clk, reset (sync, active high), step (advance one state), value (state)
module bomb_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);
  always_ff @(posedge clk) begin
    if (reset)     value <= SEED;
    else if (step) value <= {1'b0, value[7:1]} ^ (value[0] ? 8'hB8 : 8'h00);
  end
endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: up to N_BOMBS falling alien bombs. Requests launches from the
// alien controller, moves bombs once per frame tick, detects player hits and
// renders the bomb pixel.
//   s_clk, reset (sync, active high), clk_0 (frame tick), pause (freeze)
//   fire        : launch handshake (alien_bomb_if.master)
//   player_*    : player hit box; pixel_x/y : render position
//   bomb_pixel  : combinational render output
//   player_hit  : one-cycle pulse after a tick in which a bomb hit the player
//   bombs_active: per-slot active flags
// Optional build macro BOMB_SHOT_CANCEL_EN adds shot_x/shot_y/shot_active and
// shot_cancel: bombs touching an active 2x8 player shot are destroyed.
module alien_bomb
  import game_pkg::*;
#(
  parameter int         N_BOMBS         = 3,
  parameter int         N_COLS          = 11,
  parameter int         BOMB_WIDTH      = 2,
  parameter int         BOMB_HEIGHT     = 6,
  parameter int         BOMB_VELOCITY   = 2,
  parameter int         Y_BOTTOM_LIMIT  = game_pkg::Y_BOTTOM_LIMIT,
  parameter int         COOLDOWN_FRAMES = 45,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic               s_clk,
  input  logic               reset,
  input  logic               clk_0,
  input  logic               pause,
  alien_bomb_if.master       fire,
  input  coord_t             player_x,
  input  coord_t             player_y,
  input  logic [5:0]         player_w,
  input  logic [5:0]         player_h,
  input  coord_t             pixel_x,
  input  coord_t             pixel_y,
`ifdef BOMB_SHOT_CANCEL_EN
  input  coord_t             shot_x,
  input  coord_t             shot_y,
  input  logic               shot_active,
  output logic               shot_cancel,
`endif
  output logic               bomb_pixel,
  output logic               player_hit,
  output logic [N_BOMBS-1:0] bombs_active
);
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  fire_state_t              state, state_nxt;
  logic [CD_W-1:0]          cooldown, cd_nxt, cd_dec;
  logic [3:0]               req_col, col_nxt;
  logic [7:0]               lfsr;
  logic                     tick, load, has_free;
  logic [N_BOMBS-1:0]       active, load_oh, hit, past_bottom, shot_hit, pix;
  coord_t [N_BOMBS-1:0]     slot_x, slot_y, y_new;
  coord_t                   launch_x;
  logic [10:0]              px0, px1, py0, py1;

  assign tick     = clk_0 & ~pause;
  assign has_free = ~&active;
  assign launch_x = fire.fire_x - coord_t'(BOMB_WIDTH / 2);
  assign px0 = {1'b0, player_x};
  assign px1 = px0 + 11'(player_w);
  assign py0 = {1'b0, player_y};
  assign py1 = py0 + 11'(player_h);

  bomb_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(s_clk), .reset(reset), .step(tick), .value(lfsr)
  );

  // Per-slot motion, collision and render terms. Collision boxes use the
  // post-move position; rendering uses the current one.
  for (genvar i = 0; i < N_BOMBS; i++) begin : g_slot
    logic [10:0] bx0, bx1, by0, by1, ry0;
    assign y_new[i] = slot_y[i] + coord_t'(BOMB_VELOCITY);
    assign bx0 = {1'b0, slot_x[i]};
    assign bx1 = bx0 + 11'(BOMB_WIDTH);
    assign by0 = {1'b0, y_new[i]};
    assign by1 = by0 + 11'(BOMB_HEIGHT);
    assign ry0 = {1'b0, slot_y[i]};
    assign hit[i]         = active[i] && box_overlap(bx0, bx1, by0, by1, px0, px1, py0, py1);
    assign past_bottom[i] = y_new[i] > coord_t'(Y_BOTTOM_LIMIT);
    assign pix[i] = active[i]
                 && ({1'b0, pixel_x} >= bx0) && ({1'b0, pixel_x} < bx0 + 11'(BOMB_WIDTH))
                 && ({1'b0, pixel_y} >= ry0) && ({1'b0, pixel_y} < ry0 + 11'(BOMB_HEIGHT));
`ifdef BOMB_SHOT_CANCEL_EN
    assign shot_hit[i] = active[i] && shot_active
                      && box_overlap(bx0, bx1, by0, by1,
                                     {1'b0, shot_x}, {1'b0, shot_x} + 11'd2,
                                     {1'b0, shot_y}, {1'b0, shot_y} + 11'd8);
`else
    assign shot_hit[i] = 1'b0;
`endif
  end

  assign bomb_pixel    = |pix;
  assign bombs_active  = active;
  assign fire.fire_req = (state == REQ);
  assign fire.fire_col = req_col;

  // Lowest-index free slot, one-hot, gated by an accepted valid ack.
  always_comb begin
    load_oh = '0;
    for (int i = N_BOMBS - 1; i >= 0; i--)
      if (!active[i]) begin
        load_oh    = '0;
        load_oh[i] = 1'b1;
      end
    if (!load) load_oh = '0;
  end

  // Launch FSM. A request is raised on the tick where the cooldown reaches
  // (or already sits at) zero with a free slot; the column is captured then
  // and held for the whole request.
  always_comb begin
    state_nxt = state;
    cd_nxt    = cooldown;
    col_nxt   = req_col;
    load      = 1'b0;
    cd_dec    = (cooldown != '0) ? cooldown - CD_W'(1) : '0;
    unique case (state)
      IDLE: if (tick) begin
        cd_nxt = cd_dec;
        if (cd_dec == '0 && has_free) begin
          state_nxt = REQ;
          col_nxt   = col_fold(lfsr, N_COLS);
        end
      end
      REQ: if (!pause && fire.fire_ack) begin
        state_nxt = IDLE;
        if (fire.fire_valid && has_free) begin
          load   = 1'b1;
          cd_nxt = CD_W'(COOLDOWN_FRAMES);
        end else begin
          cd_nxt = CD_W'(1);   // retry on the next tick with a fresh column
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (reset) begin
      state      <= IDLE;
      cooldown   <= CD_W'(COOLDOWN_FRAMES);
      req_col    <= '0;
      active     <= '0;
      slot_x     <= '0;
      slot_y     <= '0;
      player_hit <= 1'b0;
`ifdef BOMB_SHOT_CANCEL_EN
      shot_cancel <= 1'b0;
`endif
    end else if (!pause) begin
      state      <= state_nxt;
      cooldown   <= cd_nxt;
      req_col    <= col_nxt;
      player_hit <= tick && (|hit);
`ifdef BOMB_SHOT_CANCEL_EN
      shot_cancel <= tick && (|(shot_hit & ~hit));
`endif
      for (int i = 0; i < N_BOMBS; i++) begin
        // Moving slots are active; a loading slot is free, so the two never
        // coincide and a freshly loaded bomb skips this tick's move.
        if (tick && active[i]) begin
          if (hit[i] || shot_hit[i] || past_bottom[i]) active[i] <= 1'b0;
          else                                         slot_y[i] <= y_new[i];
        end else if (load_oh[i]) begin
          active[i] <= 1'b1;
          slot_x[i] <= launch_x;
          slot_y[i] <= fire.fire_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_alien_bomb.sv
module tb_alien_bomb;
  logic       s_clk = 1'b0;
  logic       reset, clk_0, pause;
  logic [9:0] player_x, player_y, pixel_x, pixel_y;
  logic [5:0] player_w, player_h;
  logic       bomb_pixel, player_hit;
  logic [2:0] bombs_active;
  int         n_pass = 0, n_total = 0;
  logic [7:0] m_lfsr;

  alien_bomb_if bus();

  alien_bomb dut (
    .s_clk(s_clk), .reset(reset), .clk_0(clk_0), .pause(pause), .fire(bus),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .bomb_pixel(bomb_pixel),
    .player_hit(player_hit), .bombs_active(bombs_active)
  );

  always #5 s_clk = ~s_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [3:0] col_of(input logic [7:0] l);
    logic [3:0] c;
    c = l[3:0];
    return (c >= 4'd11) ? c - 4'd11 : c;
  endfunction

  task automatic frame();
    @(negedge s_clk); clk_0 = 1'b1;
    @(negedge s_clk); clk_0 = 1'b0;
    if (!pause) m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic apply_reset();
    reset = 1'b1; clk_0 = 1'b0; pause = 1'b0;
    bus.fire_ack = 1'b0; bus.fire_valid = 1'b0; bus.fire_x = '0; bus.fire_y = '0;
    pixel_x = '0; pixel_y = '0;
    repeat (2) @(negedge s_clk);
    reset = 1'b0;
    m_lfsr = 8'hA5;
  endtask

  task automatic far_player();
    player_x = 10'd500; player_y = 10'd10; player_w = 6'd16; player_h = 6'd8;
  endtask

  // Runs frames until fire_req; n = frames taken (-1 on timeout), col = model column.
  task automatic wait_req(input int limit, output int n, output logic [3:0] col);
    n = -1; col = '0;
    for (int i = 1; i <= limit; i++) begin
      col = col_of(m_lfsr);
      frame();
      if (bus.fire_req) begin n = i; break; end
    end
  endtask

  task automatic do_ack(input logic valid, input int x, input int y);
    @(negedge s_clk);
    bus.fire_ack = 1'b1; bus.fire_valid = valid; bus.fire_x = 10'(x); bus.fire_y = 10'(y);
    @(negedge s_clk);
    bus.fire_ack = 1'b0; bus.fire_valid = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic v);
    pixel_x = 10'(x); pixel_y = 10'(y);
    #1 v = bomb_pixel;
  endtask

  task automatic test_reset();
    logic v;
    far_player();
    apply_reset();
    probe(0, 0, v);
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.fire_req); else n_pass++;
    n_total++; if (player_hit !== 1'b0) $display("FAIL rst_hit: got %b want 0", player_hit); else n_pass++;
    n_total++; if (bombs_active !== 3'b000) $display("FAIL rst_active: got %b want 000", bombs_active); else n_pass++;
    n_total++; if (v !== 1'b0) $display("FAIL rst_pixel: got %b want 0", v); else n_pass++;
  endtask

  task automatic test_first_launch();
    logic v;
    logic [3:0] ec;
    apply_reset();
    repeat (44) frame();
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL req_f44: got %b want 0", bus.fire_req); else n_pass++;
    ec = col_of(m_lfsr);
    frame();
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL req_f45: got %b want 1", bus.fire_req); else n_pass++;
    n_total++; if (bus.fire_col !== ec) $display("FAIL col_f45: got %0d want %0d", bus.fire_col, ec); else n_pass++;
    do_ack(1'b1, 100, 200);
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL req_drop: got %b want 0", bus.fire_req); else n_pass++;
    n_total++; if (bombs_active !== 3'b001) $display("FAIL load_slot0: got %b want 001", bombs_active); else n_pass++;
    probe(99, 200, v);  n_total++; if (v !== 1'b1) $display("FAIL pix_99_200: got %b want 1", v); else n_pass++;
    probe(100, 205, v); n_total++; if (v !== 1'b1) $display("FAIL pix_100_205: got %b want 1", v); else n_pass++;
    probe(98, 200, v);  n_total++; if (v !== 1'b0) $display("FAIL pix_98_200: got %b want 0", v); else n_pass++;
    probe(101, 200, v); n_total++; if (v !== 1'b0) $display("FAIL pix_101_200: got %b want 0", v); else n_pass++;
    probe(99, 206, v);  n_total++; if (v !== 1'b0) $display("FAIL pix_99_206: got %b want 0", v); else n_pass++;
    frame();
    probe(99, 202, v);  n_total++; if (v !== 1'b1) $display("FAIL move1_top: got %b want 1", v); else n_pass++;
    probe(99, 201, v);  n_total++; if (v !== 1'b0) $display("FAIL move1_above: got %b want 0", v); else n_pass++;
    frame();
    probe(99, 204, v);  n_total++; if (v !== 1'b1) $display("FAIL move2_top: got %b want 1", v); else n_pass++;
    probe(99, 203, v);  n_total++; if (v !== 1'b0) $display("FAIL move2_above: got %b want 0", v); else n_pass++;
  endtask

  task automatic test_bottom();
    int n;
    logic v;
    logic [3:0] ec;
    apply_reset();
    wait_req(60, n, ec);
    n_total++; if (n !== 45) $display("FAIL bot_launch_frame: got %0d want 45", n); else n_pass++;
    do_ack(1'b1, 301, 458);
    frame();
    probe(300, 460, v);
    n_total++; if (bombs_active !== 3'b001) $display("FAIL bot_keep460: got %b want 001", bombs_active); else n_pass++;
    n_total++; if (v !== 1'b1) $display("FAIL bot_pix460: got %b want 1", v); else n_pass++;
    frame();
    n_total++; if (bombs_active !== 3'b000) $display("FAIL bot_retire: got %b want 000", bombs_active); else n_pass++;
    n_total++; if (player_hit !== 1'b0) $display("FAIL bot_nohit: got %b want 0", player_hit); else n_pass++;
  endtask

  task automatic test_hit();
    int n;
    logic [3:0] ec;
    player_x = 10'd90; player_y = 10'd220; player_w = 6'd16; player_h = 6'd8;
    apply_reset();
    wait_req(60, n, ec);
    do_ack(1'b1, 100, 210);
    frame();   // y 212: bottom edge 218 short of 220
    n_total++; if (bombs_active !== 3'b001) $display("FAIL hit_pre_active: got %b want 001", bombs_active); else n_pass++;
    n_total++; if (player_hit !== 1'b0) $display("FAIL hit_pre_pulse: got %b want 0", player_hit); else n_pass++;
    frame();   // y 214: bottom edge 220 touches player top
    n_total++; if (player_hit !== 1'b1) $display("FAIL hit_pulse: got %b want 1", player_hit); else n_pass++;
    n_total++; if (bombs_active !== 3'b000) $display("FAIL hit_clear: got %b want 000", bombs_active); else n_pass++;
    @(negedge s_clk);
    n_total++; if (player_hit !== 1'b0) $display("FAIL hit_one_cycle: got %b want 0", player_hit); else n_pass++;
    far_player();
  endtask

  task automatic test_full();
    int n;
    logic [3:0] ec;
    logic req_seen;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      wait_req(60, n, ec);
      n_total++; if (n !== 45) $display("FAIL full_launch%0d: got %0d want 45", k, n); else n_pass++;
      do_ack(1'b1, 100 + 50 * k, 10);
    end
    n_total++; if (bombs_active !== 3'b111) $display("FAIL full_all: got %b want 111", bombs_active); else n_pass++;
    req_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      frame();
      if (bus.fire_req) req_seen = 1'b1;
      if (bombs_active !== 3'b111) break;
    end
    n_total++; if (req_seen !== 1'b0) $display("FAIL full_noreq: got %b want 0", req_seen); else n_pass++;
    n_total++; if (bombs_active !== 3'b110) $display("FAIL full_free0: got %b want 110", bombs_active); else n_pass++;
    frame();
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL full_req_T1: got %b want 1", bus.fire_req); else n_pass++;
    do_ack(1'b1, 400, 10);
    n_total++; if (bombs_active !== 3'b111) $display("FAIL full_reload: got %b want 111", bombs_active); else n_pass++;
  endtask

  task automatic test_nack();
    int n;
    logic [3:0] ec;
    apply_reset();
    wait_req(60, n, ec);
    n_total++; if (bus.fire_col !== ec) $display("FAIL nack_col1: got %0d want %0d", bus.fire_col, ec); else n_pass++;
    do_ack(1'b0, 100, 200);
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL nack_drop: got %b want 0", bus.fire_req); else n_pass++;
    n_total++; if (bombs_active !== 3'b000) $display("FAIL nack_noload: got %b want 000", bombs_active); else n_pass++;
    ec = col_of(m_lfsr);
    frame();
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL nack_retry: got %b want 1", bus.fire_req); else n_pass++;
    n_total++; if (bus.fire_col !== ec) $display("FAIL nack_col2: got %0d want %0d", bus.fire_col, ec); else n_pass++;
    reset = 1'b1;
    @(negedge s_clk);
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL req_reset: got %b want 0", bus.fire_req); else n_pass++;
    reset = 1'b0;
    m_lfsr = 8'hA5;
  endtask

  task automatic test_pause();
    int n;
    logic v;
    logic [3:0] ec;
    apply_reset();
    wait_req(60, n, ec);
    do_ack(1'b1, 200, 100);   // slot0 at x=199, y=100
    repeat (20) frame();      // y=140, cooldown 25
    pause = 1'b1;
    repeat (10) frame();
    probe(199, 140, v); n_total++; if (v !== 1'b1) $display("FAIL pz_idle_pos: got %b want 1", v); else n_pass++;
    probe(199, 139, v); n_total++; if (v !== 1'b0) $display("FAIL pz_idle_above: got %b want 0", v); else n_pass++;
    pause = 1'b0;
    repeat (24) frame();
    n_total++; if (bus.fire_req !== 1'b0) $display("FAIL pz_cd_hold: got %b want 0", bus.fire_req); else n_pass++;
    ec = col_of(m_lfsr);
    frame();                  // 45th unpaused frame, y=190
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL pz_cd_req: got %b want 1", bus.fire_req); else n_pass++;
    pause = 1'b1;
    repeat (10) frame();
    do_ack(1'b1, 300, 50);
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL pz_req_held: got %b want 1", bus.fire_req); else n_pass++;
    n_total++; if (bus.fire_col !== ec) $display("FAIL pz_col_held: got %0d want %0d", bus.fire_col, ec); else n_pass++;
    n_total++; if (bombs_active !== 3'b001) $display("FAIL pz_ack_ignored: got %b want 001", bombs_active); else n_pass++;
    probe(199, 190, v); n_total++; if (v !== 1'b1) $display("FAIL pz_req_pos: got %b want 1", v); else n_pass++;
    probe(199, 189, v); n_total++; if (v !== 1'b0) $display("FAIL pz_req_above: got %b want 0", v); else n_pass++;
    pause = 1'b0;
    frame();
    probe(199, 192, v); n_total++; if (v !== 1'b1) $display("FAIL pz_resume_pos: got %b want 1", v); else n_pass++;
    probe(199, 191, v); n_total++; if (v !== 1'b0) $display("FAIL pz_resume_above: got %b want 0", v); else n_pass++;
    do_ack(1'b0, 0, 0);
    ec = col_of(m_lfsr);
    frame();
    n_total++; if (bus.fire_req !== 1'b1) $display("FAIL pz_retry_req: got %b want 1", bus.fire_req); else n_pass++;
    n_total++; if (bus.fire_col !== ec) $display("FAIL pz_lfsr_col: got %0d want %0d", bus.fire_col, ec); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_launch();
    test_bottom();
    test_hit();
    test_full();
    test_nack();
    test_pause();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
